// File: rtl/key_debouncer.sv
// Multi-channel push-button debouncer: two-flop synchronizer, polarity normalisation,
// and one four-state qualification FSM with stability counter per key.
module key_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     key_raw,
    output logic [WIDTH-1:0]     key_level,
    output logic [WIDTH-1:0]     key_press,
    output logic [WIDTH-1:0]     key_release,
    output logic [2*WIDTH-1:0]   state_dbg
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_PIN}};

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_pin;
    logic [WIDTH-1:0] sync_q;

    // Synchronizer resets to the released pin level so leaving reset is not seen as a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= IDLE_VEC;
            sync_pin  <= IDLE_VEC;
        end else begin
            sync_meta <= key_raw;
            sync_pin  <= sync_meta;
        end
    end

    assign sync_q = ACTIVE_LOW ? ~sync_pin : sync_pin;

    for (genvar k = 0; k < WIDTH; k++) begin : g_key
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             level_nxt;
        logic             press_nxt;
        logic             release_nxt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= RELEASED;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        // A single opposite sample in a WAIT state drops back and forfeits the partial count.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                RELEASED: begin
                    if (sync_q[k]) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_q[k]) begin
                        state_nxt = RELEASED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_q[k]) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_q[k]) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = RELEASED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_comb begin
            level_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
            press_nxt   = (state == PRESS_WAIT) && (state_nxt == PRESSED);
            release_nxt = (state == RELEASE_WAIT) && (state_nxt == RELEASED);
        end

        assign key_level[k]         = level_q;
        assign key_press[k]         = press_q;
        assign key_release[k]       = release_q;
        assign state_dbg[2*k +: 2]  = state;
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomized and directed bench for key_debouncer, checked every cycle against a
// run-length model of the debounce rule.
module tb_key_debouncer;

    localparam int W = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [W-1:0]   key_raw = '1;
    logic [W-1:0]   key_level;
    logic [W-1:0]   key_press;
    logic [W-1:0]   key_release;
    logic [2*W-1:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    key_debouncer #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(19), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .key_level(key_level),
        .key_press(key_press), .key_release(key_release), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a key's accepted level flips once D consecutive synchronized samples
    // disagree with it; samples reach the decision two clocks after the pin.
    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_press = '0;
    logic [W-1:0] m_rel   = '0;
    int           m_run [W];
    logic [W-1:0] exp_q [$] = '{4'b0000, 4'b0000};

    always @(posedge clk) begin
        logic [W-1:0] s;
        if (!reset_n) begin
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            exp_q   = '{4'b0000, 4'b0000};
            for (int k = 0; k < W; k++) m_run[k] = 0;
        end else begin
            s = exp_q.pop_front();
            exp_q.push_back(~key_raw);
            m_press = '0;
            m_rel   = '0;
            for (int k = 0; k < W; k++) begin
                m_run[k] = (s[k] != m_level[k]) ? m_run[k] + 1 : 0;
                if (m_run[k] == D) begin
                    m_level[k] = ~m_level[k];
                    m_run[k]   = 0;
                    if (m_level[k]) m_press[k] = 1'b1;
                    else            m_rel[k]   = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_level",   32'(key_level),   reset_n ? 32'(m_level) : 32'd0);
            check("cmp_press",   32'(key_press),   reset_n ? 32'(m_press) : 32'd0);
            check("cmp_release", 32'(key_release), reset_n ? 32'(m_rel)   : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        key_raw = '1;
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_outputs", 32'({key_level, key_press, key_release}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_press(input logic [W-1:0] mask, output int idx);
        idx = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if ((key_press & mask) != '0) begin
                idx = i;
                break;
            end
        end
    endtask

    task automatic wait_release(input logic [W-1:0] mask, output int idx);
        idx = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if ((key_release & mask) != '0) begin
                idx = i;
                break;
            end
        end
    endtask

    initial begin
        int idx;
        int cnt;
        int bad;
        int hold [W];

        tick();
        tick();
        chk_en = 1'b1;
        apply_reset();

        // Single key pressed from before E0: accepted after E5, pulse gone after E6.
        key_raw = 4'b1110;
        wait_press(4'b1111, idx);
        check("lat_press_edge", 32'(idx), 32'd5);
        check("lat_press_vec", 32'(key_press), 32'h1);
        check("lat_level_vec", 32'(key_level), 32'h1);
        check("model_press_pin", 32'(m_press), 32'h1);
        tick();
        check("press_one_cycle", 32'(key_press), 32'h0);

        // Bouncing key 0 at 2-cycle period never qualifies; final settle does.
        apply_reset();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            key_raw[0] = ((c / 2) % 2) != 0;
            tick();
            if (key_press[0]) cnt++;
        end
        check("bounce_no_press", 32'(cnt), 32'd0);
        key_raw[0] = 1'b0;
        wait_press(4'b0001, idx);
        check("bounce_settle_edge", 32'(idx), 32'd5);

        // Release latency, then a one-cycle glitch restarting release qualification.
        key_raw[0] = 1'b1;
        wait_release(4'b0001, idx);
        check("release_edge", 32'(idx), 32'd5);
        check("release_level", 32'(key_level), 32'h0);
        key_raw[0] = 1'b0;
        wait_press(4'b0001, idx);
        check("repress_edge", 32'(idx), 32'd5);
        key_raw[0] = 1'b1;
        cnt = 0;
        tick();
        if (key_release[0]) cnt++;
        tick();
        if (key_release[0]) cnt++;
        key_raw[0] = 1'b0;
        tick();
        if (key_release[0]) cnt++;
        key_raw[0] = 1'b1;
        check("glitch_no_release", 32'(cnt), 32'd0);
        check("glitch_level_held", 32'(key_level[0]), 32'd1);
        wait_release(4'b0001, idx);
        check("glitch_restart_edge", 32'(idx), 32'd5);

        // All keys together, then only key 2 released.
        apply_reset();
        key_raw = 4'b0000;
        wait_press(4'b1111, idx);
        check("all_press_edge", 32'(idx), 32'd5);
        check("all_press_vec", 32'(key_press), 32'hF);
        key_raw = 4'b0100;
        wait_release(4'b1111, idx);
        check("k2_release_edge", 32'(idx), 32'd5);
        check("k2_release_vec", 32'(key_release), 32'h4);
        check("k2_level_vec", 32'(key_level), 32'hB);

        // Reset in the middle of qualification discards the partial count.
        apply_reset();
        key_raw = 4'b1101;
        for (int i = 0; i < 4; i++) tick();
        check("midq_no_press", 32'(key_press), 32'h0);
        reset_n = 1'b0;
        tick();
        check("midq_rst_outputs", 32'({key_level, key_press, key_release}), 32'd0);
        tick();
        check("midq_rst_outputs2", 32'({key_level, key_press, key_release}), 32'd0);
        reset_n = 1'b1;
        wait_press(4'b1111, idx);
        check("midq_press_edge", 32'(idx), 32'd5);
        check("midq_press_vec", 32'(key_press), 32'h2);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (key_press[1]) cnt++;
        end
        check("midq_no_repeat", 32'(cnt), 32'd0);

        // Long hold on key 3: one pulse, level stays high once accepted.
        apply_reset();
        key_raw = 4'b0111;
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (key_press[3]) cnt++;
            if (cnt > 0 && !key_level[3]) bad++;
        end
        check("hold_press_count", 32'(cnt), 32'd1);
        check("hold_level_drop", 32'(bad), 32'd0);

        // Randomized per-key hold times around the debounce threshold.
        apply_reset();
        for (int k = 0; k < W; k++) hold[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < W; k++) begin
                if (hold[k] == 0) begin
                    key_raw[k] = 1'($urandom_range(0, 1));
                    hold[k]    = int'($urandom_range(1, 10));
                end
                hold[k]--;
            end
            if (c == 1500) reset_n = 1'b0;
            if (c == 1503) reset_n = 1'b1;
            tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
